// File: rtl/mc_control_fsm.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences each instruction
// through fetch/decode/execute/memory/writeback and drives every datapath control.
module mc_control_fsm #(
    parameter bit TRAP_ON_ILLEGAL = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [5:0] i_opcode,
    input  logic       i_zero,
    output logic       o_pc_en,
    output logic       o_iord,
    output logic       o_mem_write,
    output logic       o_ir_write,
    output logic       o_reg_write,
    output logic       o_reg_dst,
    output logic       o_mem_to_reg,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_alu_op,
    output logic [1:0] o_pc_src,
    output logic       o_instr_done,
    output logic       o_illegal_op,
    output logic       o_halted,
    output logic [3:0] o_state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // branch marks BRANCH, where pc_en comes from the live zero flag instead.
    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       instr_done;
        logic       halted;
        logic       branch;
    } ctrl_t;

    function automatic ctrl_t ctrl_for(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:  begin c.ir_write = 1'b1; c.pc_en = 1'b1; c.alu_src_b = 2'b01; end
            S_DECODE: c.alu_src_b = 2'b11;
            S_MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_MEMRD:  c.iord = 1'b1;
            S_MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.instr_done = 1'b1; end
            S_MEMWR:  begin c.iord = 1'b1; c.mem_write = 1'b1; c.instr_done = 1'b1; end
            S_EXEC:   begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
            S_ALUWB:  begin c.reg_write = 1'b1; c.reg_dst = 1'b1; c.instr_done = 1'b1; end
            S_BRANCH: begin
                c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_src = 2'b01;
                c.branch = 1'b1; c.instr_done = 1'b1;
            end
            S_ADDIEX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_ADDIWB: begin c.reg_write = 1'b1; c.instr_done = 1'b1; end
            S_JUMP:   begin c.pc_src = 2'b10; c.pc_en = 1'b1; c.instr_done = 1'b1; end
            S_HALT:   c.halted = 1'b1;
            default:  c = '0;
        endcase
        return c;
    endfunction

    state_t r_state;
    ctrl_t  r_ctrl;
    state_t w_next;
    logic   w_illegal;

    always_comb begin
        w_next    = S_FETCH;
        w_illegal = 1'b0;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (i_opcode)
                    OP_RTYPE:    w_next = S_EXEC;
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_BEQ:      w_next = S_BRANCH;
                    OP_ADDI:     w_next = S_ADDIEX;
                    OP_J:        w_next = S_JUMP;
                    default: begin
                        w_illegal = 1'b1;
                        w_next    = TRAP_ON_ILLEGAL ? S_HALT : S_FETCH;
                    end
                endcase
            end
            S_MEMADR: w_next = (i_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_next = S_MEMWB;
            S_EXEC:   w_next = S_ALUWB;
            S_ADDIEX: w_next = S_ADDIWB;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_FETCH;
        endcase
    end

    // Outputs are registered alongside the state, computed from the state being entered.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_FETCH;
            r_ctrl  <= ctrl_for(S_FETCH);
        end else begin
            r_state <= w_next;
            r_ctrl  <= ctrl_for(w_next);
        end
    end

    assign o_pc_en      = r_ctrl.pc_en | (r_ctrl.branch & i_zero);
    assign o_iord       = r_ctrl.iord;
    assign o_mem_write  = r_ctrl.mem_write;
    assign o_ir_write   = r_ctrl.ir_write;
    assign o_reg_write  = r_ctrl.reg_write;
    assign o_reg_dst    = r_ctrl.reg_dst;
    assign o_mem_to_reg = r_ctrl.mem_to_reg;
    assign o_alu_src_a  = r_ctrl.alu_src_a;
    assign o_alu_src_b  = r_ctrl.alu_src_b;
    assign o_alu_op     = r_ctrl.alu_op;
    assign o_pc_src     = r_ctrl.pc_src;
    assign o_instr_done = r_ctrl.instr_done;
    assign o_halted     = r_ctrl.halted;
    assign o_illegal_op = w_illegal;
    assign o_state      = r_state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: two instances (skip and trap on illegal opcodes) share
// stimulus; a per-instruction state-sequence model predicts state and outputs.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       zero = 1'b0;

    logic       pc_en0, iord0, mem_write0, ir_write0, reg_write0, reg_dst0, mem_to_reg0, alu_src_a0;
    logic [1:0] alu_src_b0, alu_op0, pc_src0;
    logic       instr_done0, illegal_op0, halted0;
    logic [3:0] state0;
    logic       pc_en1, iord1, mem_write1, ir_write1, reg_write1, reg_dst1, mem_to_reg1, alu_src_a1;
    logic [1:0] alu_src_b1, alu_op1, pc_src1;
    logic       instr_done1, illegal_op1, halted1;
    logic [3:0] state1;

    always #5 clk = ~clk;

    mc_control_fsm #(.TRAP_ON_ILLEGAL(1'b0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_opcode(opcode), .i_zero(zero),
        .o_pc_en(pc_en0), .o_iord(iord0), .o_mem_write(mem_write0), .o_ir_write(ir_write0),
        .o_reg_write(reg_write0), .o_reg_dst(reg_dst0), .o_mem_to_reg(mem_to_reg0),
        .o_alu_src_a(alu_src_a0), .o_alu_src_b(alu_src_b0), .o_alu_op(alu_op0),
        .o_pc_src(pc_src0), .o_instr_done(instr_done0), .o_illegal_op(illegal_op0),
        .o_halted(halted0), .o_state(state0)
    );

    mc_control_fsm #(.TRAP_ON_ILLEGAL(1'b1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_opcode(opcode), .i_zero(zero),
        .o_pc_en(pc_en1), .o_iord(iord1), .o_mem_write(mem_write1), .o_ir_write(ir_write1),
        .o_reg_write(reg_write1), .o_reg_dst(reg_dst1), .o_mem_to_reg(mem_to_reg1),
        .o_alu_src_a(alu_src_a1), .o_alu_src_b(alu_src_b1), .o_alu_op(alu_op1),
        .o_pc_src(pc_src1), .o_instr_done(instr_done1), .o_illegal_op(illegal_op1),
        .o_halted(halted1), .o_state(state1)
    );

    wire [16:0] obs0 = {pc_en0, iord0, mem_write0, ir_write0, reg_write0, reg_dst0, mem_to_reg0,
                        alu_src_a0, alu_src_b0, alu_op0, pc_src0, instr_done0, illegal_op0, halted0};
    wire [16:0] obs1 = {pc_en1, iord1, mem_write1, ir_write1, reg_write1, reg_dst1, mem_to_reg1,
                        alu_src_a1, alu_src_b1, alu_op1, pc_src1, instr_done1, illegal_op1, halted1};

    int checks = 0;
    int errors = 0;
    int exp0 = 0;
    int exp1 = 0;
    int q0[$];
    int q1[$];
    bit leg0 = 1'b0;
    int exp_done = 0;
    int obs_done = 0;
    logic [5:0] prog[$];
    logic [5:0] legal_ops[6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};

    function automatic bit is_legal(input logic [5:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Expected control vector for a state, straight from the state/output table.
    function automatic logic [16:0] exp_vec(input int st, input bit z, input bit ill);
        logic pe, io, mw, iw, rw, rd, m2r, sa, dn, il, hl;
        logic [1:0] sb, op, ps;
        {pe, io, mw, iw, rw, rd, m2r, sa, dn, il, hl} = '0;
        sb = 2'b00; op = 2'b00; ps = 2'b00;
        case (st)
            0:  begin iw = 1; pe = 1; sb = 2'b01; end
            1:  begin sb = 2'b11; il = ill; end
            2:  begin sa = 1; sb = 2'b10; end
            3:  io = 1;
            4:  begin rw = 1; m2r = 1; dn = 1; end
            5:  begin io = 1; mw = 1; dn = 1; end
            6:  begin sa = 1; op = 2'b10; end
            7:  begin rw = 1; rd = 1; dn = 1; end
            8:  begin sa = 1; op = 2'b01; ps = 2'b01; pe = z; dn = 1; end
            9:  begin sa = 1; sb = 2'b10; end
            10: begin rw = 1; dn = 1; end
            11: begin ps = 2'b10; pe = 1; dn = 1; end
            12: hl = 1;
            default: ;
        endcase
        return {pe, io, mw, iw, rw, rd, m2r, sa, sb, op, ps, dn, il, hl};
    endfunction

    task automatic push_seq(input logic [5:0] op, input bit trap, output int q[$]);
        case (op)
            6'b100011: q = '{1, 2, 3, 4};
            6'b101011: q = '{1, 2, 5};
            6'b000000: q = '{1, 6, 7};
            6'b001000: q = '{1, 9, 10};
            6'b000100: q = '{1, 8};
            6'b000010: q = '{1, 11};
            default:   if (trap) q = '{1, 12}; else q = '{1};
        endcase
    endtask

    task automatic cycle(input bit r);
        bit ill;
        @(negedge clk);
        rst  = r;
        zero = 1'($urandom_range(0, 1));
        if (exp0 == 0) begin
            if (prog.size() > 0) opcode = prog.pop_front();
            else if ($urandom_range(0, 7) == 0) begin
                do opcode = 6'($urandom_range(0, 63)); while (is_legal(opcode));
            end else opcode = legal_ops[$urandom_range(0, 5)];
            leg0 = is_legal(opcode);
            push_seq(opcode, 1'b0, q0);
            if (exp1 == 0) push_seq(opcode, 1'b1, q1);
        end
        #1;
        ill = !is_legal(opcode);
        obs_done += int'(instr_done0);
        checks++;
        assert (state0 === 4'(exp0))
            else begin errors++; $error("FAIL state0 got %0d want %0d", state0, exp0); end
        checks++;
        assert (obs0 === exp_vec(exp0, zero, ill && exp0 == 1))
            else begin errors++; $error("FAIL outs0 st %0d got %b want %b", exp0, obs0, exp_vec(exp0, zero, ill && exp0 == 1)); end
        checks++;
        assert (state1 === 4'(exp1))
            else begin errors++; $error("FAIL state1 got %0d want %0d", state1, exp1); end
        checks++;
        assert (obs1 === exp_vec(exp1, zero, ill && exp1 == 1))
            else begin errors++; $error("FAIL outs1 st %0d got %b want %b", exp1, obs1, exp_vec(exp1, zero, ill && exp1 == 1)); end
        @(posedge clk);
        if (r) begin
            exp0 = 0; exp1 = 0; q0.delete(); q1.delete();
        end else begin
            if (q0.size() > 0) begin
                exp0 = q0.pop_front();
                if (q0.size() == 0 && leg0) exp_done++;
            end else exp0 = 0;
            if (q1.size() > 0) exp1 = q1.pop_front();
            else if (exp1 != 12) exp1 = 0;
        end
    endtask

    initial begin
        int g;
        rst = 1'b1;
        @(posedge clk);
        exp0 = 0; exp1 = 0;
        cycle(1'b1);

        // lw, R-type, two beq, sw then j, then an illegal opcode
        prog = '{6'b100011, 6'b000000, 6'b000100, 6'b000100, 6'b101011, 6'b000010, 6'b111111};
        g = 0;
        while ((prog.size() > 0 || exp0 != 0) && g < 200) begin cycle(1'b0); g++; end
        checks++;
        assert (g < 200) else begin errors++; $error("FAIL directed_drain got %0d want <200", g); end

        // trap instance sits in HALT, then reset pulls it out
        repeat (10) cycle(1'b0);
        cycle(1'b1);
        repeat (3) cycle(1'b0);

        // reset in the middle of a load, while in MEMRD
        g = 0;
        while (exp0 != 0 && g < 20) begin cycle(1'b0); g++; end
        prog.push_back(6'b100011);
        g = 0;
        while (exp0 != 3 && g < 20) begin cycle(1'b0); g++; end
        checks++;
        assert (g < 20) else begin errors++; $error("FAIL reach_memrd got %0d want <20", g); end
        cycle(1'b1);
        repeat (4) cycle(1'b0);

        repeat (3000) cycle($urandom_range(0, 49) == 0);

        checks++;
        assert (obs_done === exp_done)
            else begin errors++; $error("FAIL done_count got %0d want %0d", obs_done, exp_done); end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Main control state machine for the multi-cycle MIPS datapath.
- Each instruction is sequenced over 3–5 cycles through fetch, decode, execute, memory and writeback.
- Drives the shared ALU's 2-bit alu_op into alu_control, plus all mux selects and write enables for the PC, instruction register, memory and register file.
- Sits between the instruction register's opcode field and the datapath.

Parameters:
- TRAP_ON_ILLEGAL, 0, 1 = an unsupported opcode enters HALT until reset; 0 = the opcode is skipped and the FSM returns to FETCH.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- opcode  in  6  IR[31:26]; stable from the cycle after FETCH until the next FETCH
- zero  in  1  ALU zero flag, combinational from the current cycle
- pc_en  out  1  PC register write enable
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_write  out  1  memory write enable
- ir_write  out  1  instruction register load
- reg_write  out  1  register file write enable
- reg_dst  out  1  destination register: 0 = rt, 1 = rd
- mem_to_reg  out  1  writeback data: 0 = ALUOut, 1 = memory data register
- alu_src_a  out  1  ALU A operand: 0 = PC, 1 = register A
- alu_src_b  out  2  ALU B operand: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- alu_op  out  2  to alu_control: 00 = add, 01 = subtract, 10 = decode funct
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- instr_done  out  1  one-cycle pulse in the final state of each legal instruction
- illegal_op  out  1  one-cycle pulse in DECODE when the opcode is unsupported
- halted  out  1  high while in HALT
- state  out  4  current state encoding, for debug

Behaviour:
- Moore FSM with a single 4-bit state register.
- All outputs decode from the state, except that pc_en in BRANCH also depends on zero.
- Every output not listed for a state is 0.
- State encodings and outputs:
  - FETCH (0): ir_write=1, pc_en=1, alu_src_b=01; everything else 0.
  - DECODE (1): alu_src_b=11 (branch target is precomputed into ALUOut).
  - MEMADR (2): alu_src_a=1, alu_src_b=10, alu_op=00.
  - MEMRD (3): iord=1.
  - MEMWB (4): reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1.
  - MEMWR (5): iord=1, mem_write=1, instr_done=1.
  - EXEC (6): alu_src_a=1, alu_src_b=00, alu_op=10.
  - ALUWB (7): reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1.
  - BRANCH (8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero, instr_done=1.
  - ADDIEX (9): alu_src_a=1, alu_src_b=10, alu_op=00.
  - ADDIWB (10): reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1.
  - JUMP (11): pc_src=10, pc_en=1, instr_done=1.
  - HALT (12): halted=1, every enable 0.
- Transitions:
  - FETCH -> DECODE.
  - DECODE on opcode:
    - 000000 (R-type) -> EXEC
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000100 (beq) -> BRANCH
    - 001000 (addi) -> ADDIEX
    - 000010 (j) -> JUMP
    - any other opcode -> pulse illegal_op, then HALT if TRAP_ON_ILLEGAL=1, otherwise FETCH.
  - MEMADR -> MEMRD for lw, MEMWR for sw (re-examines opcode).
  - MEMRD -> MEMWB.
  - EXEC -> ALUWB.
  - ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP -> FETCH.
  - HALT -> HALT.
  - Encodings 13–15 -> FETCH, with all outputs 0.
- Latency from FETCH through the final state, inclusive:
  - lw: 5 cycles
  - sw, R-type, addi: 4 cycles
  - beq, j: 3 cycles
- Reset:
  - rst is sampled only on the rising clk edge and has priority over every transition, including HALT and mid-instruction states.
  - The cycle after reset is asserted, state = FETCH.
  - Outputs while in reset follow FETCH decoding: ir_write=1, pc_en=1.
  - The PC and IR themselves are held by their own resets.
- Opcode is ignored in every state except DECODE and MEMADR.
- zero is ignored outside BRANCH.

Test Plan:
- Reset, then lw (opcode 100011) -> states 0,1,2,3,4,0. In state 4: reg_write=1, mem_to_reg=1, instr_done=1. In state 3: iord=1.
- R-type (000000) -> states 0,1,6,7. alu_op=10 in state 6. In state 7: reg_dst=1, reg_write=1.
- beq (000100) with zero=1 -> pc_en=1 and pc_src=01 in state 8. Repeat with zero=0 -> pc_en=0 in state 8, next state 0.
- sw then j back-to-back -> mem_write=1 only in state 5. In state 11: pc_src=10, pc_en=1. Exactly two instr_done pulses.
- Opcode 111111 with TRAP_ON_ILLEGAL=0 -> illegal_op pulses in state 1, next state 0. With TRAP_ON_ILLEGAL=1 -> state 12, halted=1 held for 10 cycles.
- Assert rst in state 3 (lw) and separately in HALT -> the next cycle is state 0, and no reg_write or mem_write pulse occurs.
